// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } if_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC            = 32'd4;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetched packet that arrived while the pipe was frozen.
module if_skid_buffer
    import if_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       unload,
    input  logic       clear,
    input  fetch_pkt_t din,
    output fetch_pkt_t dout,
    output logic       valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear || unload) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ready and feeds the IF/ID register.
//   state | meaning
//   FETCH | request outstanding at pc_q
//   DRAIN | wrong-path request in flight; wait for it and discard the word
//   HOLD  | fetched packet parked in skid while frozen; no request
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Br_taken,
    input  logic [31:0] Br_addr,
    input  logic        IF_flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        inst_valid
);

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] br_target;
    logic        accept;
    fetch_pkt_t  fetch_pkt;
    fetch_pkt_t  skid_pkt;
    logic        skid_valid;
    logic        skid_load;
    logic        skid_unload;
    logic        skid_clear;

    assign br_target = {Br_addr[31:2], 2'b00};
    assign accept    = (state_q == FETCH) && imem_ready;
    assign fetch_pkt = '{pc_plus4: pc_q + PC_INC, instr: imem_rdata};

    assign skid_clear  = Br_taken;
    assign skid_load   = accept && freeze && !Br_taken;
    assign skid_unload = (state_q == HOLD) && !freeze && !Br_taken;

    assign imem_req  = !rst && (state_q != HOLD);
    assign imem_addr = (state_q == DRAIN) ? req_addr_q : pc_q;

    if_skid_buffer u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (skid_clear),
        .din    (fetch_pkt),
        .dout   (skid_pkt),
        .valid  (skid_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            PC          <= '0;
            Instruction <= NOP_INSTR;
            inst_valid  <= 1'b0;
        end else if (Br_taken) begin
            // Redirect wins over freeze; a flush bubbles the outputs even when frozen.
            pc_q <= br_target;
            if (IF_flush || !freeze) begin
                Instruction <= NOP_INSTR;
                inst_valid  <= 1'b0;
            end
            case (state_q)
                FETCH: begin
                    if (!imem_ready) begin
                        state_q    <= DRAIN;
                        req_addr_q <= pc_q;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                DRAIN:   state_q <= imem_ready ? FETCH : DRAIN;
                default: state_q <= FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        pc_q <= pc_q + PC_INC;
                        if (freeze) begin
                            state_q <= HOLD;
                        end else begin
                            PC          <= fetch_pkt.pc_plus4;
                            Instruction <= fetch_pkt.instr;
                            inst_valid  <= 1'b1;
                        end
                    end else if (!freeze) begin
                        Instruction <= NOP_INSTR;
                        inst_valid  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        PC          <= skid_pkt.pc_plus4;
                        Instruction <= skid_pkt.instr;
                        inst_valid  <= skid_valid;
                        state_q     <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        state_q <= FETCH;
                    end
                    if (!freeze) begin
                        Instruction <= NOP_INSTR;
                        inst_valid  <= 1'b0;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_if_stage;
    import if_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        Br_taken = 1'b0;
    logic [31:0] Br_addr = '0;
    logic        IF_flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        inst_valid;

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .Br_taken    (Br_taken),
        .Br_addr     (Br_addr),
        .IF_flush    (IF_flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .Instruction (Instruction),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          busy = 0;
    int          wait_left = 0;
    logic [31:0] busy_addr = '0;
    bit          rand_lat = 0;
    int          fixed_lat = 0;
    logic        req_seen = 1'b0;
    logic        ready_seen = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Memory model: one request at a time, answered after a chosen number of wait cycles.
    task automatic drive_mem();
        if (imem_req === 1'b1) begin
            if (!busy) begin
                busy      = 1;
                busy_addr = imem_addr;
                wait_left = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            end else begin
                chk("addr_stable", imem_addr, busy_addr);
            end
            imem_ready = (wait_left == 0);
            imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        end else begin
            if (busy) chk("req_held", {31'b0, imem_req}, 32'd1);
            imem_ready = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
        req_seen   = imem_req;
        ready_seen = imem_ready;
    endtask

    task automatic cycle();
        #1;
        drive_mem();
        @(posedge clk);
        #1;
        if (req_seen && ready_seen) busy = 0;
        else if (busy && wait_left > 0) wait_left--;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        freeze = 1'b0; Br_taken = 1'b0; IF_flush = 1'b0; Br_addr = '0;
        imem_ready = 1'b0; imem_rdata = '0;
        busy = 0; wait_left = 0;
        #1;
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instruction, NOP);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic branch(input logic [31:0] tgt);
        Br_taken = 1'b1; IF_flush = 1'b1; Br_addr = tgt;
    endtask

    task automatic unbranch();
        Br_taken = 1'b0; IF_flush = 1'b0; Br_addr = '0;
    endtask

    logic [31:0] exp_next, p_pc, p_in;
    logic        p_v;
    bit          f, b;
    int          n_valid;

    initial begin
        #2;
        // Zero-wait memory: one instruction per cycle
        do_reset();
        rand_lat = 0; fixed_lat = 0;
        chk("t1_first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", imem_addr, 32'(4 * i));
            cycle();
            chk("t1_pc", PC, 32'(4 * i + 4));
            chk("t1_instr", Instruction, mem_word(32'(4 * i)));
            chk("t1_valid", {31'b0, inst_valid}, 32'd1);
        end

        // Two wait states: address held 3 cycles, two bubbles between instructions
        do_reset();
        fixed_lat = 2;
        for (int k = 0; k < 3; k++) begin
            chk("t2_addr0", imem_addr, 32'h0);
            cycle();
            if (k < 2) begin
                chk("t2_bubble_valid", {31'b0, inst_valid}, 32'd0);
                chk("t2_bubble_instr", Instruction, NOP);
            end
        end
        chk("t2_pc4", PC, 32'd4);
        chk("t2_instr0", Instruction, mem_word(32'h0));
        chk("t2_valid0", {31'b0, inst_valid}, 32'd1);
        chk("t2_addr4", imem_addr, 32'd4);
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("t2_bub_valid", {31'b0, inst_valid}, 32'd0);
            chk("t2_bub_instr", Instruction, NOP);
            chk("t2_bub_pc", PC, 32'd4);
        end
        cycle();
        chk("t2_pc8", PC, 32'd8);
        chk("t2_instr4", Instruction, mem_word(32'd4));

        // Freeze while the word for address 8 arrives
        do_reset();
        fixed_lat = 0;
        repeat (2) cycle();
        chk("t3_addr8", imem_addr, 32'd8);
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t3_hold_req", {31'b0, imem_req}, 32'd0);
            chk("t3_hold_pc", PC, 32'd8);
            chk("t3_hold_instr", Instruction, mem_word(32'd4));
            chk("t3_hold_valid", {31'b0, inst_valid}, 32'd1);
        end
        freeze = 1'b0;
        cycle();
        chk("t3_rel_pc", PC, 32'd12);
        chk("t3_rel_instr", Instruction, mem_word(32'd8));
        chk("t3_rel_addr", imem_addr, 32'd12);
        cycle();
        chk("t3_next_pc", PC, 32'd16);
        chk("t3_next_instr", Instruction, mem_word(32'd12));

        // Branch while a 3-wait request for 0x20 is outstanding
        do_reset();
        fixed_lat = 0;
        repeat (8) cycle();
        chk("t4_addr20", imem_addr, 32'h20);
        fixed_lat = 3;
        cycle();
        branch(32'h0000_0103);
        cycle();
        unbranch();
        chk("t4_drain_addr", imem_addr, 32'h20);
        chk("t4_drain_req", {31'b0, imem_req}, 32'd1);
        chk("t4_drain_valid", {31'b0, inst_valid}, 32'd0);
        cycle();
        chk("t4_wait_valid", {31'b0, inst_valid}, 32'd0);
        cycle();
        chk("t4_discard_valid", {31'b0, inst_valid}, 32'd0);
        chk("t4_discard_instr", Instruction, NOP);
        chk("t4_target_addr", imem_addr, 32'h100);
        fixed_lat = 0;
        cycle();
        chk("t4_target_pc", PC, 32'h104);
        chk("t4_target_instr", Instruction, mem_word(32'h100));
        chk("t4_target_valid", {31'b0, inst_valid}, 32'd1);

        // Branch together with imem_ready and freeze
        do_reset();
        fixed_lat = 0;
        repeat (2) cycle();
        chk("t5_addr8", imem_addr, 32'd8);
        freeze = 1'b1;
        branch(32'h100);
        cycle();
        chk("t5_flush_valid", {31'b0, inst_valid}, 32'd0);
        chk("t5_flush_instr", Instruction, NOP);
        chk("t5_addr100", imem_addr, 32'h100);
        chk("t5_req", {31'b0, imem_req}, 32'd1);
        freeze = 1'b0;
        unbranch();
        cycle();
        chk("t5_pc", PC, 32'h104);
        chk("t5_instr", Instruction, mem_word(32'h100));

        // PC wraps modulo 2^32
        branch(32'hFFFF_FFFC);
        cycle();
        unbranch();
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_pc", PC, 32'h0);
        chk("wrap_instr", Instruction, mem_word(32'hFFFF_FFFC));
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Reset in the middle of a wait
        do_reset();
        fixed_lat = 0;
        repeat (3) cycle();
        fixed_lat = 3;
        cycle();
        chk("t6_wait_addr", imem_addr, 32'd12);
        do_reset();
        chk("t6_restart_addr", imem_addr, 32'h0);
        chk("t6_restart_req", {31'b0, imem_req}, 32'd1);
        fixed_lat = 0;
        cycle();
        chk("t6_pc", PC, 32'd4);
        chk("t6_instr", Instruction, mem_word(32'h0));

        // Randomized traffic: every presented instruction follows the program order from the last target
        do_reset();
        rand_lat = 1;
        exp_next = 32'h0;
        n_valid = 0;
        for (int i = 0; i < 600; i++) begin
            f = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 19) == 0);
            freeze = f;
            if (b) branch($urandom());
            else unbranch();
            p_pc = PC; p_in = Instruction; p_v = inst_valid;
            cycle();
            if (b) begin
                chk("rnd_flush_valid", {31'b0, inst_valid}, 32'd0);
                chk("rnd_flush_instr", Instruction, NOP);
                exp_next = {Br_addr[31:2], 2'b00};
            end else if (f) begin
                chk("rnd_hold_pc", PC, p_pc);
                chk("rnd_hold_instr", Instruction, p_in);
                chk("rnd_hold_valid", {31'b0, inst_valid}, {31'b0, p_v});
            end else if (inst_valid === 1'b1) begin
                chk("rnd_pc", PC, exp_next + 32'd4);
                chk("rnd_instr", Instruction, mem_word(exp_next));
                exp_next = exp_next + 32'd4;
                n_valid++;
            end else begin
                chk("rnd_bubble_instr", Instruction, NOP);
                chk("rnd_bubble_pc", PC, p_pc);
            end
        end
        unbranch();
        freeze = 1'b0;
        chk("rnd_progress", {31'b0, n_valid >= 50}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
